// File: rtl/player_motion_pkg.sv
// ----------------------------------------------------------------------------
// player_motion_pkg
// Shared types and default constants for the player motion controller.
//   lane_state_t : horizontal slide FSM states
//   jump_state_t : vertical jump FSM states
//   lane_x()     : screen x of a lane centre
// ----------------------------------------------------------------------------
package player_motion_pkg;

   typedef enum logic {L_IDLE, L_SLIDE}  lane_state_t;
   typedef enum logic {J_GROUND, J_AIR}  jump_state_t;

   localparam logic [10:0]       LANE_X0_DEF      = 11'd256;
   localparam logic [10:0]       LANE_PITCH_DEF   = 11'd256;
   localparam logic [10:0]       LANE_STEP_PX_DEF = 11'd16;
   localparam logic signed [7:0] JUMP_V0_DEF      = 8'sd24;
   localparam logic signed [7:0] GRAVITY_DEF      = 8'sd1;
   localparam logic [1:0]        MAX_LANE_DEF     = 2'd2;
   localparam logic [1:0]        HOME_LANE        = 2'd1;

   // Centre x of a lane; origin and pitch default to the standard layout.
   function automatic logic [10:0] lane_x(input logic [1:0]  lane,
                                          input logic [10:0] x0    = LANE_X0_DEF,
                                          input logic [10:0] pitch = LANE_PITCH_DEF);
      return x0 + pitch * {9'd0, lane};
   endfunction

endpackage

// File: rtl/player_motion_controller_jump_arc.sv
// ----------------------------------------------------------------------------
// player_jump_arc
// Jump edge detection and parabolic arc, advanced once per frame tick.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   clear_i         : synchronous clear back to the grounded idle state
//   tick_i          : frame strobe, the arc advances only on it
//   jump_req_i      : debounced jump level; a rising edge arms a jump
//   y_o             : height above ground in px
//   airborne_o      : high while in the arc
//   jump_start_o    : one-cycle pulse on takeoff
//   land_o          : one-cycle pulse on touchdown
// ----------------------------------------------------------------------------
module player_jump_arc
   import player_motion_pkg::*;
#(
   parameter logic signed [7:0] JUMP_V0 = JUMP_V0_DEF,
   parameter logic signed [7:0] GRAVITY = GRAVITY_DEF
)(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clear_i,
   input  logic       tick_i,
   input  logic       jump_req_i,
   output logic [9:0] y_o,
   output logic       airborne_o,
   output logic       jump_start_o,
   output logic       land_o
);

   jump_state_t       state_q, state_d;
   logic signed [7:0] vel_q, vel_d;
   logic [9:0]        y_q, y_d;
   logic              req_q;
   logic              pending_q, pending_d;
   logic              jump_start_q, jump_start_d;
   logic              land_q, land_d;
   logic              rise;
   logic signed [11:0] next_y;

   assign rise   = jump_req_i & ~req_q;
   // Height plus signed velocity at 12 bits so a descent below ground goes negative.
   assign next_y = $signed({2'b00, y_q}) + $signed({{4{vel_q[7]}}, vel_q});

   always_comb begin
      state_d      = state_q;
      vel_d        = vel_q;
      y_d          = y_q;
      pending_d    = pending_q;
      jump_start_d = 1'b0;
      land_d       = 1'b0;

      // Edges seen mid-air are dropped rather than queued for after landing.
      if (rise && state_q != J_AIR) begin
         pending_d = 1'b1;
      end

      if (tick_i) begin
         case (state_q)
            J_GROUND: begin
               if (pending_q) begin
                  state_d      = J_AIR;
                  vel_d        = JUMP_V0;
                  y_d          = 10'd0;
                  pending_d    = 1'b0;
                  jump_start_d = 1'b1;
               end
            end
            J_AIR: begin
               if (next_y <= 12'sd0) begin
                  state_d = J_GROUND;
                  y_d     = 10'd0;
                  land_d  = 1'b1;
               end else begin
                  y_d   = next_y[9:0];
                  vel_d = vel_q - GRAVITY;
               end
            end
            default: state_d = J_GROUND;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= J_GROUND;
         vel_q        <= '0;
         y_q          <= '0;
         req_q        <= 1'b0;
         pending_q    <= 1'b0;
         jump_start_q <= 1'b0;
         land_q       <= 1'b0;
      end else if (clear_i) begin
         state_q      <= J_GROUND;
         vel_q        <= '0;
         y_q          <= '0;
         req_q        <= 1'b0;
         pending_q    <= 1'b0;
         jump_start_q <= 1'b0;
         land_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         vel_q        <= vel_d;
         y_q          <= y_d;
         req_q        <= jump_req_i;
         pending_q    <= pending_d;
         jump_start_q <= jump_start_d;
         land_q       <= land_d;
      end
   end

   assign y_o          = y_q;
   assign airborne_o   = (state_q == J_AIR);
   assign jump_start_o = jump_start_q;
   assign land_o       = land_q;

endmodule

// File: rtl/player_motion_controller.sv
// ----------------------------------------------------------------------------
// player_motion_controller
// Sequences the player sprite's lane slides and jumps once per video frame.
//   system_clock_in : system clock
//   system_reset_n  : asynchronous active-low reset
//   frame_tick      : one-cycle frame strobe; all motion advances on it
//   game_active     : low holds everything in the reset state
//   lane_target     : requested lane (values above MAX_LANE ignored)
//   jump_req        : jump level; rising edge requests a jump
//   player_x/_y     : sprite centre x, height above ground
//   current_lane    : last lane fully reached
//   airborne/sliding: motion status
//   jump_start/land : one-cycle event pulses
// ----------------------------------------------------------------------------
module player_motion_controller
   import player_motion_pkg::*;
#(
   parameter logic [10:0]       LANE_X0      = LANE_X0_DEF,
   parameter logic [10:0]       LANE_PITCH   = LANE_PITCH_DEF,
   parameter logic [10:0]       LANE_STEP_PX = LANE_STEP_PX_DEF,
   parameter logic signed [7:0] JUMP_V0      = JUMP_V0_DEF,
   parameter logic signed [7:0] GRAVITY      = GRAVITY_DEF,
   parameter logic [1:0]        MAX_LANE     = MAX_LANE_DEF
)(
   input  logic        system_clock_in,
   input  logic        system_reset_n,
   input  logic        frame_tick,
   input  logic        game_active,
   input  logic [1:0]  lane_target,
   input  logic        jump_req,
   output logic [10:0] player_x,
   output logic [9:0]  player_y,
   output logic [1:0]  current_lane,
   output logic        airborne,
   output logic        sliding,
   output logic        jump_start,
   output logic        land
);

   lane_state_t lane_state_q, lane_state_d;
   logic [1:0]  lane_q, lane_d;
   logic [1:0]  dest_q, dest_d;
   logic [10:0] x_q, x_d;
   logic [10:0] dest_x;
   logic [10:0] stepped_x;

   assign dest_x    = lane_x(dest_q, LANE_X0, LANE_PITCH);
   assign stepped_x = (dest_q > lane_q) ? x_q + LANE_STEP_PX : x_q - LANE_STEP_PX;

   always_comb begin
      lane_state_d = lane_state_q;
      lane_d       = lane_q;
      dest_d       = dest_q;
      x_d          = x_q;
      if (frame_tick) begin
         case (lane_state_q)
            L_IDLE: begin
               // Only one adjacent lane per slide; farther targets are
               // picked up again once this slide completes.
               if (lane_target <= MAX_LANE && lane_target != lane_q) begin
                  dest_d       = (lane_target > lane_q) ? lane_q + 2'd1 : lane_q - 2'd1;
                  lane_state_d = L_SLIDE;
               end
            end
            L_SLIDE: begin
               x_d = stepped_x;
               if (stepped_x == dest_x) begin
                  lane_d       = dest_q;
                  lane_state_d = L_IDLE;
               end
            end
            default: lane_state_d = L_IDLE;
         endcase
      end
   end

   always_ff @(posedge system_clock_in or negedge system_reset_n) begin
      if (!system_reset_n) begin
         lane_state_q <= L_IDLE;
         lane_q       <= HOME_LANE;
         dest_q       <= HOME_LANE;
         x_q          <= lane_x(HOME_LANE, LANE_X0, LANE_PITCH);
      end else if (!game_active) begin
         lane_state_q <= L_IDLE;
         lane_q       <= HOME_LANE;
         dest_q       <= HOME_LANE;
         x_q          <= lane_x(HOME_LANE, LANE_X0, LANE_PITCH);
      end else begin
         lane_state_q <= lane_state_d;
         lane_q       <= lane_d;
         dest_q       <= dest_d;
         x_q          <= x_d;
      end
   end

   player_jump_arc #(
      .JUMP_V0 (JUMP_V0),
      .GRAVITY (GRAVITY)
   ) u_jump_arc (
      .clk_i        (system_clock_in),
      .rst_ni       (system_reset_n),
      .clear_i      (~game_active),
      .tick_i       (frame_tick),
      .jump_req_i   (jump_req),
      .y_o          (player_y),
      .airborne_o   (airborne),
      .jump_start_o (jump_start),
      .land_o       (land)
   );

   assign player_x     = x_q;
   assign current_lane = lane_q;
   assign sliding      = (lane_state_q == L_SLIDE);

endmodule

// File: tb/tb_player_motion_controller.sv
// ----------------------------------------------------------------------------
// tb_player_motion_controller
// Directed stimulus with a frame-level motion model checked every clock,
// plus hand-computed checkpoints.
// ----------------------------------------------------------------------------
module tb_player_motion_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        frame_tick;
   logic        game_active;
   logic [1:0]  lane_target;
   logic        jump_req;
   logic [10:0] player_x;
   logic [9:0]  player_y;
   logic [1:0]  current_lane;
   logic        airborne;
   logic        sliding;
   logic        jump_start;
   logic        land;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   player_motion_controller dut (
      .system_clock_in (clk),
      .system_reset_n  (rst_n),
      .frame_tick      (frame_tick),
      .game_active     (game_active),
      .lane_target     (lane_target),
      .jump_req        (jump_req),
      .player_x        (player_x),
      .player_y        (player_y),
      .current_lane    (current_lane),
      .airborne        (airborne),
      .sliding         (sliding),
      .jump_start      (jump_start),
      .land            (land)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- frame-level model ----------------
   // Lane position in px, height from the closed-form arc V0*k - G*k(k-1)/2.
   int m_x, m_y, m_lane, m_dest, m_k;
   bit m_slide, m_air, m_pending, m_prev, m_js, m_land;

   task automatic model_reset();
      m_x = 512; m_y = 0; m_lane = 1; m_dest = 1; m_k = 0;
      m_slide = 0; m_air = 0; m_pending = 0; m_prev = 0; m_js = 0; m_land = 0;
   endtask

   task automatic model_step();
      bit rise, was_air;
      int arc;
      rise    = jump_req && !m_prev;
      m_prev  = jump_req;
      was_air = m_air;
      m_js    = 0;
      m_land  = 0;
      if (frame_tick) begin
         if (!m_air && m_pending) begin
            m_air = 1; m_k = 0; m_y = 0; m_js = 1;
         end else if (m_air) begin
            m_k++;
            arc = 24 * m_k - (m_k * (m_k - 1)) / 2;
            if (arc <= 0) begin
               m_air = 0; m_y = 0; m_land = 1;
            end else begin
               m_y = arc;
            end
         end
         if (!m_slide) begin
            if (int'(lane_target) <= 2 && int'(lane_target) != m_lane) begin
               m_dest  = (int'(lane_target) > m_lane) ? m_lane + 1 : m_lane - 1;
               m_slide = 1;
            end
         end else begin
            m_x += (m_dest > m_lane) ? 16 : -16;
            if (m_x == 256 + 256 * m_dest) begin
               m_lane  = m_dest;
               m_slide = 0;
            end
         end
      end
      if (m_js) m_pending = 0;
      else if (rise && !was_air) m_pending = 1;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n || !game_active) model_reset();
         else model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("cyc_player_x",     int'(player_x),     m_x);
      chk("cyc_player_y",     int'(player_y),     m_y);
      chk("cyc_current_lane", int'(current_lane), m_lane);
      chk("cyc_airborne",     int'(airborne),     int'(m_air));
      chk("cyc_sliding",      int'(sliding),      int'(m_slide));
      chk("cyc_jump_start",   int'(jump_start),   int'(m_js));
      chk("cyc_land",         int'(land),         int'(m_land));
   end

   // ---------------- stimulus ----------------
   bit seen_js, seen_land;

   // One frame tick; pulses are captured on the first clock after it.
   task automatic do_tick();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      seen_js   = jump_start;
      seen_land = land;
      repeat (2) @(negedge clk);
   endtask

   int pulses, maxy, landed_at, slid;

   initial begin
      rst_n       = 1'b0;
      frame_tick  = 1'b0;
      game_active = 1'b1;
      lane_target = 2'd1;
      jump_req    = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_x",        int'(player_x), 512);
      chk("reset_lane",     int'(current_lane), 1);
      chk("reset_y",        int'(player_y), 0);
      chk("reset_airborne", int'(airborne), 0);
      chk("reset_sliding",  int'(sliding), 0);
      $display("TXN reset released");

      pulses = 0;
      repeat (100) begin
         do_tick();
         pulses += int'(seen_js) + int'(seen_land);
      end
      chk("idle_x", int'(player_x), 512);
      chk("idle_lane", int'(current_lane), 1);
      chk("idle_pulses", pulses, 0);
      $display("TXN 100 idle ticks x=%0d lane=%0d", player_x, current_lane);

      lane_target = 2'd2;
      do_tick();
      chk("slide_t1_sliding", int'(sliding), 1);
      chk("slide_t1_x", int'(player_x), 512);
      do_tick();
      chk("slide_t2_x", int'(player_x), 528);
      repeat (15) do_tick();
      chk("slide_t17_x", int'(player_x), 768);
      chk("slide_t17_lane", int'(current_lane), 2);
      chk("slide_t17_sliding", int'(sliding), 0);
      do_tick();
      chk("slide_after_sliding", int'(sliding), 0);
      $display("TXN slide 1->2 x=%0d lane=%0d", player_x, current_lane);

      lane_target = 2'd0;
      repeat (17) do_tick();
      chk("two_lane_mid_x", int'(player_x), 512);
      chk("two_lane_mid_lane", int'(current_lane), 1);
      repeat (17) do_tick();
      chk("two_lane_end_x", int'(player_x), 256);
      chk("two_lane_end_lane", int'(current_lane), 0);
      $display("TXN slide 2->0 x=%0d lane=%0d", player_x, current_lane);

      jump_req = 1'b1;
      repeat (2) @(negedge clk);
      do_tick();
      chk("takeoff_pulse", int'(seen_js), 1);
      chk("takeoff_airborne", int'(airborne), 1);
      chk("takeoff_y", int'(player_y), 0);
      maxy = 0;
      landed_at = 0;
      for (int t = 1; t <= 60 && landed_at == 0; t++) begin
         if (t == 5)  jump_req = 1'b0;
         if (t == 10) jump_req = 1'b1;
         do_tick();
         if (t == 1) chk("air_t1_y", int'(player_y), 24);
         if (int'(player_y) > maxy) maxy = int'(player_y);
         if (seen_land) landed_at = t;
      end
      chk("land_tick", landed_at, 49);
      chk("land_y", int'(player_y), 0);
      chk("land_airborne", int'(airborne), 0);
      chk("peak_y", maxy, 300);
      $display("TXN jump peak=%0d landed on air tick %0d", maxy, landed_at);

      pulses = 0;
      repeat (5) begin
         do_tick();
         pulses += int'(seen_js);
      end
      chk("no_retake", pulses, 0);
      lane_target = 2'd3;
      slid = 0;
      repeat (5) begin
         do_tick();
         slid += int'(sliding);
      end
      chk("bad_lane_slide", slid, 0);
      chk("bad_lane_x", int'(player_x), 256);
      $display("TXN ignored airborne edge and lane 3");

      jump_req = 1'b0;
      @(negedge clk);
      lane_target = 2'd2;
      jump_req    = 1'b1;
      repeat (2) @(negedge clk);
      repeat (20) do_tick();
      chk("combo_x", int'(player_x), 544);
      chk("combo_y", int'(player_y), 285);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_x", int'(player_x), 512);
      chk("async_y", int'(player_y), 0);
      chk("async_lane", int'(current_lane), 1);
      chk("async_airborne", int'(airborne), 0);
      chk("async_sliding", int'(sliding), 0);
      chk("async_pulses", int'(jump_start) + int'(land), 0);
      @(negedge clk);
      rst_n = 1'b1;
      $display("TXN async reset during slide and jump");

      lane_target = 2'd1;
      repeat (10) do_tick();
      chk("ga_pre_airborne", int'(airborne), 1);
      @(negedge clk);
      game_active = 1'b0;
      @(negedge clk);
      chk("ga_x", int'(player_x), 512);
      chk("ga_y", int'(player_y), 0);
      chk("ga_airborne", int'(airborne), 0);
      chk("ga_lane", int'(current_lane), 1);
      game_active = 1'b1;
      jump_req    = 1'b0;
      repeat (3) do_tick();
      chk("ga_after_airborne", int'(airborne), 0);
      $display("TXN game_active clear mid-arc");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
